sba_engine: RTL
===============

SBA_ENGINE -- requirements
Module: sba_engine

Interface
REQ-001 clk  in  1  single system clock; all state updates on its rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 reg_valid  in  1  DMI register access strobe from debug_module, one cycle per access.
REQ-004 reg_write  in  1  1 = write, 0 = read; qualified by reg_valid.
REQ-005 reg_addr  in  7  DMI register address: 0x38 sbcs, 0x39 sbaddress0, 0x3C sbdata0; other addresses ignored.
REQ-006 reg_wdata  in  32  register write data.
REQ-007 reg_rdata  out  32  read data, registered; valid the cycle after a read strobe; 0 for unmapped addresses.
REQ-008 mem_req  out  1  memory request toward mem debug data port; held until mem_gnt.
REQ-009 mem_we  out  1  1 = write request.
REQ-010 mem_addr  out  32  byte address, word-aligned (addr[1:0] forced to 0).
REQ-011 mem_be  out  4  byte enables.
REQ-012 mem_wdata  out  32  write data, replicated across byte lanes.
REQ-013 mem_gnt  in  1  request accepted this cycle.
REQ-014 mem_rvalid  in  1  read data valid; arrives at least 1 cycle after mem_gnt.
REQ-015 mem_rdata  in  32  read data.

Function
REQ-016 sbcs fields: sbversion[31:29]=1, sbbusyerror[22] W1C, sbbusy[21] RO, sbreadonaddr[20], sbaccess[19:17], sbautoincrement[16], sbreadondata[15], sberror[14:12] W1C, sbasize[11:5]=32, sbaccess32[2]=1, sbaccess16[1], sbaccess8[0]; other bits read 0.
REQ-017 FSM states IDLE, WR_REQ, RD_REQ, RD_WAIT; sbbusy = (state != IDLE).
REQ-018 Write of sbdata0 in IDLE: latch data, go WR_REQ; mem_req=1, mem_we=1 from next cycle until mem_gnt; on gnt -> IDLE.
REQ-019 Write of sbaddress0 in IDLE with sbreadonaddr=1, or read of sbdata0 in IDLE with sbreadondata=1: go RD_REQ; mem_req=1, mem_we=0 until mem_gnt -> RD_WAIT; on mem_rvalid capture data into sbdata0 -> IDLE.
REQ-020 Read of sbdata0 returns the sbdata0 value before any read it triggers.
REQ-021 On access completion (write gnt or read rvalid) with sbautoincrement=1, sbaddress0 += (1 << sbaccess), 32-bit wrap from 0xFFFFFFFC to 0.
REQ-022 Access to sbaddress0 or sbdata0 while sbbusy=1: sbbusyerror set, access ignored, no state change; sbcs writes while busy update only W1C bits.
REQ-023 While sbbusyerror=1 or sberror!=0, no new access starts; register writes still land.
REQ-024 Misaligned address for selected size: no memory request, sberror=3.
REQ-025 Unsupported sbaccess value: no memory request, sberror=4.
REQ-026 Byte enables: 32-bit 4'b1111; 16-bit 4'b0011 << (2*addr[1]); 8-bit 4'b0001 << addr[1:0].
REQ-027 Narrow reads extract the addressed lane and zero-extend into sbdata0.
REQ-028 mem_req/mem_addr/mem_be/mem_wdata stable while mem_req=1 and mem_gnt=0.

Reset
REQ-029 On rst: state IDLE, sbaddress0=0, sbdata0=0, sbaccess=2, all other sbcs RW/W1C bits 0, reg_rdata=0, mem_req=0, mem_we=0, mem_be=0.
REQ-030 rst mid-access aborts immediately; a late mem_rvalid after reset is ignored.

Configuration
REQ-031 Macro SBA_NARROW_EN defined: sbaccess 0 (8-bit) and 1 (16-bit) supported, sbaccess8=sbaccess16=1.
REQ-032 SBA_NARROW_EN undefined: only sbaccess=2 supported, sbaccess8=sbaccess16=0, sbaccess 0/1 give sberror=4.

Verification
REQ-033 sbaddress0=0x100, sbdata0 write 0xDEADBEEF -> mem_req, mem_we=1, addr 0x100, be=0xF; gnt after 3 cycles -> sbbusy clears next cycle.
REQ-034 sbreadonaddr=1, autoinc=1, sbaddress0=0x200, rdata 0x12345678 -> sbdata0=0x12345678, sbaddress0=0x204.
REQ-035 Write sbdata0 during pending access -> sbbusyerror=1, no second request; W1C 1 to bit 22 clears it.
REQ-036 sbaccess=2, address 0x102 -> no mem_req, sberror=3; later accesses blocked until W1C.
REQ-037 With SBA_NARROW_EN, 8-bit read at 0x103, mem_rdata 0xAABBCCDD -> sbdata0=0x000000AA, be=4'b1000; without macro -> sberror=4.
REQ-038 rst asserted in RD_WAIT -> next cycle state IDLE, sbbusy=0, mem_req=0; subsequent mem_rvalid leaves sbdata0=0.

Source files
------------

// File: rtl/sba_engine.sv
// System bus access engine behind the debug module's sbcs/sbaddress0/sbdata0 registers (narrow sizes with SBA_NARROW_EN).
// Latency: reg_rdata one cycle after a read strobe; mem_req rises the cycle after the triggering access.
// Backpressure: mem_req and its payload stay frozen until mem_gnt; register accesses made while busy are dropped and flagged.
module sba_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_valid,
  input  logic        reg_write,
  input  logic [6:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

`ifdef SBA_NARROW_EN
  localparam logic NARROW_EN = 1'b1;
`else
  localparam logic NARROW_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

  state_t      state;
  logic [31:0] sbaddress0;
  logic [31:0] sbdata0;
  logic        sbbusyerror;
  logic        sbreadonaddr;
  logic [2:0]  sbaccess;
  logic        sbautoincrement;
  logic        sbreadondata;
  logic [2:0]  sberror;

  logic        busy;
  logic        sel_cs, sel_addr, sel_data;
  logic        wr_data_trig, rd_addr_trig, rd_data_trig, start_try;
  logic [31:0] acc_addr, acc_data;
  logic        size_ok, aligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_rep, rd_shift, rd_lane, sbcs_val, incr;

  always_comb begin
    busy     = (state != IDLE);
    sel_cs   = reg_valid && (reg_addr == 7'h38);
    sel_addr = reg_valid && (reg_addr == 7'h39);
    sel_data = reg_valid && (reg_addr == 7'h3C);

    wr_data_trig = sel_data && reg_write && !busy;
    rd_addr_trig = sel_addr && reg_write && !busy && sbreadonaddr;
    rd_data_trig = sel_data && !reg_write && !busy && sbreadondata;
    start_try    = (wr_data_trig || rd_addr_trig || rd_data_trig) &&
                   !sbbusyerror && (sberror == 3'd0);

    // A read-on-address access targets the address being written this cycle.
    acc_addr = rd_addr_trig ? reg_wdata : sbaddress0;
    acc_data = wr_data_trig ? reg_wdata : sbdata0;

    size_ok = (sbaccess == 3'd2) ||
              (NARROW_EN && ((sbaccess == 3'd0) || (sbaccess == 3'd1)));

    aligned   = 1'b1;
    be_calc   = 4'b1111;
    wdata_rep = acc_data;
    rd_shift  = mem_rdata >> {sbaddress0[1:0], 3'b000};
    rd_lane   = mem_rdata;
    case (sbaccess)
      3'd0: begin
        be_calc   = 4'b0001 << acc_addr[1:0];
        wdata_rep = {4{acc_data[7:0]}};
        rd_lane   = {24'd0, rd_shift[7:0]};
      end
      3'd1: begin
        aligned   = !acc_addr[0];
        be_calc   = 4'b0011 << {acc_addr[1], 1'b0};
        wdata_rep = {2{acc_data[15:0]}};
        rd_lane   = {16'd0, rd_shift[15:0]};
      end
      3'd2: aligned = (acc_addr[1:0] == 2'b00);
      default: ;
    endcase

    incr     = 32'd1 << sbaccess;
    sbcs_val = {3'd1, 6'd0, sbbusyerror, busy, sbreadonaddr, sbaccess,
                sbautoincrement, sbreadondata, sberror, 7'd32, 2'd0,
                1'b1, NARROW_EN, NARROW_EN};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      sbaddress0      <= 32'd0;
      sbdata0         <= 32'd0;
      sbbusyerror     <= 1'b0;
      sbreadonaddr    <= 1'b0;
      sbaccess        <= 3'd2;
      sbautoincrement <= 1'b0;
      sbreadondata    <= 1'b0;
      sberror         <= 3'd0;
      reg_rdata       <= 32'd0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= 32'd0;
      mem_be          <= 4'd0;
      mem_wdata       <= 32'd0;
    end else begin
      if (reg_valid && !reg_write) begin
        case (reg_addr)
          7'h38:   reg_rdata <= sbcs_val;
          7'h39:   reg_rdata <= sbaddress0;
          7'h3C:   reg_rdata <= sbdata0;
          default: reg_rdata <= 32'd0;
        endcase
      end

      if ((sel_addr || sel_data) && busy)
        sbbusyerror <= 1'b1;

      if (sel_cs && reg_write) begin
        if (reg_wdata[22])
          sbbusyerror <= 1'b0;
        sberror <= sberror & ~reg_wdata[14:12];
        if (!busy) begin
          sbreadonaddr    <= reg_wdata[20];
          sbaccess        <= reg_wdata[19:17];
          sbautoincrement <= reg_wdata[16];
          sbreadondata    <= reg_wdata[15];
        end
      end

      if (sel_addr && reg_write && !busy)
        sbaddress0 <= reg_wdata;
      if (wr_data_trig)
        sbdata0 <= reg_wdata;

      case (state)
        IDLE: begin
          if (start_try) begin
            if (!size_ok)
              sberror <= 3'd4;
            else if (!aligned)
              sberror <= 3'd3;
            else begin
              mem_req   <= 1'b1;
              mem_we    <= wr_data_trig;
              mem_addr  <= {acc_addr[31:2], 2'b00};
              mem_be    <= be_calc;
              mem_wdata <= wdata_rep;
              state     <= wr_data_trig ? WR_REQ : RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'd0;
            state   <= IDLE;
            if (sbautoincrement)
              sbaddress0 <= sbaddress0 + incr;
          end
        end
        RD_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_be  <= 4'd0;
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid) begin
            sbdata0 <= rd_lane;
            state   <= IDLE;
            if (sbautoincrement)
              sbaddress0 <= sbaddress0 + incr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
